tia_object_position_counter: RTL and testbench
==============================================

Name: tia_object_position_counter

Overview:
- Parametrised horizontal position counter for TIA movable objects (players, missiles).
- Counts object clocks modulo one scanline.
- Decodes the NUSIZ copy field into start strobes for the main copy and the close, medium and far copies.
- Adds an HMOVE extra-clock input, copy index and size-scale outputs, so one block serves both players and missiles.

Parameters:
WIDTH, 8, counter width in bits.
LINE_LEN, 160, counts per line; the counter wraps LINE_LEN-1 -> 0.
START_WIDTH, 4, start strobe length in counts.
CLOSE_OFS, 16, close copy offset.
MED_OFS, 32, medium copy offset.
FAR_OFS, 64, far copy offset.

Ports:
motck  in  1  object motion clock; all state changes on its rising edge.
pre  in  1  position reset; synchronous, active-high.
pec_bar  in  1  count enable, active-low.
hm_stb  in  1  HMOVE extra-clock request for this cycle, active-high.
nusiz  in  3  copy/size select (nz2..nz0).
count  out  WIDTH  current position count.
start_bar  out  1  low while any enabled copy is in its start window.
fstob  out  1  high while the main copy (offset 0) is in its start window.
copy_idx  out  2  active copy: 0 main, 1 close, 2 medium, 3 far; 0 when start_bar=1.
scale  out  2  pixel stretch: 0 = x1, 1 = x2, 2 = x4.

Behaviour:
- Reset (pre=1 at rising edge): count<=0, start_bar<=0, fstob<=1, copy_idx<=0. pre has priority over pec_bar and hm_stb.
- Reset mid-line restarts the main-copy window from count 0. Any in-progress strobe is cut and restarted; no merge, no glitch.
- Advance condition: (pec_bar==0) | hm_stb. Advance is +1 per cycle even when both are set; there is no double step.
- With no advance condition, count and all outputs hold.
- Wrap: count==LINE_LEN-1 with advance -> 0. The main-copy window starts on the cycle after the wrap.
- Copy enable table from nusiz:
  000: main only.
  001: main, close.
  010: main, medium.
  011: main, close, medium.
  100: main, far.
  101: main only, scale 1.
  110: main, medium, far.
  111: main only, scale 2.
  All other codes: scale 0.
- Window for offset k: k <= count <= k+START_WIDTH-1.
- start_bar, fstob and copy_idx are registered. Each is the decode of the count value being loaded, so it is coherent with count on the same cycle: zero latency relative to count, one motck after the causing edge.
- scale is a registered decode of nusiz. A nusiz change takes effect on the next edge, including mid-window.
- A copy disabled mid-window drops start_bar on the next edge.
- Windows never overlap. Legal parameters require 0 < START_WIDTH <= CLOSE_OFS-0, MED_OFS-CLOSE_OFS >= START_WIDTH, FAR_OFS-MED_OFS >= START_WIDTH, and FAR_OFS+START_WIDTH <= LINE_LEN. Illegal parameters cause an elaboration-time error.
- ceil(log2(LINE_LEN)) <= WIDTH; comparisons are unsigned.
- Freeze: with pec_bar=1 and hm_stb=0 inside a window, start_bar stays low indefinitely. This is required for HMOVE positioning.

Test Plan:
- Reset, then pec_bar=0 and nusiz=000 for 2 lines.
  -> start_bar=0 and fstob=1 at counts 0..3 only; count 159 -> 0; start_bar=1 at all other counts.
- Sweep nusiz 001..110, 160 counts each.
  -> start_bar=0 exactly at offsets 16/32/64 per table for 4 counts.
  -> copy_idx = 1/2/3 in those windows; fstob=0 in those windows.
- nusiz=101 then 111.
  -> scale=1 then 2, starting the edge after the change; only the main window is present.
- pec_bar=1 at count 17 for 10 cycles, with hm_stb pulsed 3 times.
  -> count goes 17 -> 20 only on hm_stb edges; start_bar=0 through count 19, then 1 at count 20.
- pre=1 at count 34 with nusiz=010.
  -> next edge: count=0, start_bar=0, copy_idx=0.
  -> medium window next occurs at counts 32..35.
  -> pec_bar=0 together with hm_stb=1 advances count by exactly 1.
- Re-run the 001..110 nusiz sweep of scenario 2 with LINE_LEN=228, WIDTH=8, START_WIDTH=2, CLOSE_OFS=8, MED_OFS=16, FAR_OFS=32.
  -> wrap at 227 -> 0; 2-count windows at offsets 0/8/16/32.

Source files
------------

// File: rtl/tia_object_position_counter.sv
// Horizontal position counter for TIA players/missiles: counts object clocks per
// scanline and decodes NUSIZ into main/close/medium/far copy start strobes.
module tia_object_position_counter #(
  parameter int WIDTH       = 8,
  parameter int LINE_LEN    = 160,
  parameter int START_WIDTH = 4,
  parameter int CLOSE_OFS   = 16,
  parameter int MED_OFS     = 32,
  parameter int FAR_OFS     = 64
) (
  input  logic             motck,
  input  logic             pre,
  input  logic             pec_bar,
  input  logic             hm_stb,
  input  logic [2:0]       nusiz,
  output logic [WIDTH-1:0] count,
  output logic             start_bar,
  output logic             fstob,
  output logic [1:0]       copy_idx,
  output logic [1:0]       scale
);

  if (START_WIDTH <= 0 || START_WIDTH > CLOSE_OFS ||
      MED_OFS - CLOSE_OFS < START_WIDTH || FAR_OFS - MED_OFS < START_WIDTH ||
      FAR_OFS + START_WIDTH > LINE_LEN || $clog2(LINE_LEN) > WIDTH) begin : g_bad_params
    $error("tia_object_position_counter: illegal window/line parameters");
  end

  localparam logic [WIDTH-1:0] LAST     = WIDTH'(LINE_LEN - 1);
  localparam logic [WIDTH-1:0] MAIN_HI  = WIDTH'(START_WIDTH - 1);
  localparam logic [WIDTH-1:0] CLOSE_LO = WIDTH'(CLOSE_OFS);
  localparam logic [WIDTH-1:0] CLOSE_HI = WIDTH'(CLOSE_OFS + START_WIDTH - 1);
  localparam logic [WIDTH-1:0] MED_LO   = WIDTH'(MED_OFS);
  localparam logic [WIDTH-1:0] MED_HI   = WIDTH'(MED_OFS + START_WIDTH - 1);
  localparam logic [WIDTH-1:0] FAR_LO   = WIDTH'(FAR_OFS);
  localparam logic [WIDTH-1:0] FAR_HI   = WIDTH'(FAR_OFS + START_WIDTH - 1);

  // Extra-copy enables as {far, medium, close}; the main copy is always present.
  function automatic logic [2:0] copy_enables(input logic [2:0] nz);
    logic [2:0] en;
    case (nz)
      3'b001:  en = 3'b001;
      3'b010:  en = 3'b010;
      3'b011:  en = 3'b011;
      3'b100:  en = 3'b100;
      3'b110:  en = 3'b110;
      default: en = 3'b000;
    endcase
    return en;
  endfunction

  function automatic logic [1:0] scale_of(input logic [2:0] nz);
    logic [1:0] s;
    case (nz)
      3'b101:  s = 2'd1;
      3'b111:  s = 2'd2;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

  // Returns {start_bar, fstob, copy_idx} for a given count and copy selection.
  function automatic logic [3:0] window_decode(input logic [WIDTH-1:0] c,
                                               input logic [2:0] nz);
    logic [2:0] en;
    logic [3:0] dec;
    en = copy_enables(nz);
    if (c <= MAIN_HI)                                 dec = 4'b0100;
    else if (en[0] && c >= CLOSE_LO && c <= CLOSE_HI) dec = 4'b0001;
    else if (en[1] && c >= MED_LO && c <= MED_HI)     dec = 4'b0010;
    else if (en[2] && c >= FAR_LO && c <= FAR_HI)     dec = 4'b0011;
    else                                              dec = 4'b1000;
    return dec;
  endfunction

  logic [WIDTH-1:0] count_nx;
  logic [3:0]       dec_nx;

  // Next-count / decode stage; strobes decode the value being loaded so they
  // line up with count on the same cycle.
  always_comb begin
    count_nx = count;
    if (!pec_bar || hm_stb)
      count_nx = (count == LAST) ? '0 : count + 1'b1;
    dec_nx = window_decode(count_nx, nusiz);
  end

  // Register stage.
  always_ff @(posedge motck) begin
    if (pre) begin
      count     <= '0;
      start_bar <= 1'b0;
      fstob     <= 1'b1;
      copy_idx  <= 2'd0;
    end else begin
      count                          <= count_nx;
      {start_bar, fstob, copy_idx}   <= dec_nx;
    end
    scale <= scale_of(nusiz);
  end

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Randomized self-checking bench for tia_object_position_counter: default
// 160-count configuration plus a 228-count configuration with 2-count windows.
module tb_tia_object_position_counter;

  logic motck = 1'b0;
  always #5 motck = ~motck;

  logic       pre_a, pec_a, hm_a;
  logic [2:0] nz_a;
  logic [7:0] count_a;
  logic       sb_a, fs_a;
  logic [1:0] ci_a, sc_a;

  logic       pre_b, pec_b, hm_b;
  logic [2:0] nz_b;
  logic [7:0] count_b;
  logic       sb_b, fs_b;
  logic [1:0] ci_b, sc_b;

  tia_object_position_counter dut_a (
    .motck(motck), .pre(pre_a), .pec_bar(pec_a), .hm_stb(hm_a), .nusiz(nz_a),
    .count(count_a), .start_bar(sb_a), .fstob(fs_a), .copy_idx(ci_a), .scale(sc_a)
  );

  tia_object_position_counter #(
    .WIDTH(8), .LINE_LEN(228), .START_WIDTH(2),
    .CLOSE_OFS(8), .MED_OFS(16), .FAR_OFS(32)
  ) dut_b (
    .motck(motck), .pre(pre_b), .pec_bar(pec_b), .hm_stb(hm_b), .nusiz(nz_b),
    .count(count_b), .start_bar(sb_b), .fstob(fs_b), .copy_idx(ci_b), .scale(sc_b)
  );

  int checks = 0;
  int failures = 0;

  int         m_cnt_a, m_cnt_b;
  logic [2:0] m_nz_a, m_nz_b;
  logic [1:0] m_sc_a, m_sc_b;

  // Reference: which copies exist for a nusiz code, and where each starts.
  function automatic logic [3:0] ref_dec(input int c, input logic [2:0] nz, input int sw,
                                         input int c_ofs, input int m_ofs, input int f_ofs);
    int ofs [4];
    bit [3:0] en;
    ofs = '{0, c_ofs, m_ofs, f_ofs};
    case (nz)
      3'd1:    en = 4'b0011;
      3'd2:    en = 4'b0101;
      3'd3:    en = 4'b0111;
      3'd4:    en = 4'b1001;
      3'd6:    en = 4'b1101;
      default: en = 4'b0001;
    endcase
    for (int k = 0; k < 4; k++)
      if (en[k] && c >= ofs[k] && c < ofs[k] + sw)
        return {1'b0, (k == 0), 2'(k)};
    return 4'b1000;
  endfunction

  function automatic logic [1:0] ref_scale(input logic [2:0] nz);
    if (nz == 3'd5) return 2'd1;
    if (nz == 3'd7) return 2'd2;
    return 2'd0;
  endfunction

  task automatic cyc_a(input bit p, input bit pecb, input bit hm, input logic [2:0] nz);
    @(negedge motck);
    pre_a = p; pec_a = pecb; hm_a = hm; nz_a = nz;
    @(posedge motck);
    if (p) m_cnt_a = 0;
    else if (!pecb || hm) m_cnt_a = (m_cnt_a + 1) % 160;
    m_nz_a = nz;
    m_sc_a = ref_scale(nz);
    #1;
  endtask

  task automatic cyc_b(input bit p, input bit pecb, input bit hm, input logic [2:0] nz);
    @(negedge motck);
    pre_b = p; pec_b = pecb; hm_b = hm; nz_b = nz;
    @(posedge motck);
    if (p) m_cnt_b = 0;
    else if (!pecb || hm) m_cnt_b = (m_cnt_b + 1) % 228;
    m_nz_b = nz;
    m_sc_b = ref_scale(nz);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    cyc_a(1, 1, 0, 3'd0);
    checks++;
    if (count_a !== 8'd0 || sb_a !== 1'b0 || fs_a !== 1'b1 || ci_a !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: count=%0d sb=%b fs=%b idx=%0d, expected 0 0 1 0",
               count_a, sb_a, fs_a, ci_a);
    end
    for (int i = 0; i < 320; i++) begin
      cyc_a(0, 0, 0, 3'd0);
      exp = ref_dec(m_cnt_a, m_nz_a, 4, 16, 32, 64);
      checks++;
      if (count_a !== 8'(m_cnt_a) || {sb_a, fs_a, ci_a} !== exp) begin
        failures++;
        $display("FAIL main_lines: count=%0d dec=%b, expected count=%0d dec=%b",
                 count_a, {sb_a, fs_a, ci_a}, m_cnt_a, exp);
      end
    end
  endtask

  task automatic test_sweep_a;
    logic [3:0] exp;
    cyc_a(1, 0, 0, 3'd1);
    for (int nz = 1; nz <= 6; nz++) begin
      for (int i = 0; i < 200; i++) begin
        cyc_a(0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), 3'(nz));
        exp = ref_dec(m_cnt_a, m_nz_a, 4, 16, 32, 64);
        checks++;
        if (count_a !== 8'(m_cnt_a) || {sb_a, fs_a, ci_a} !== exp || sc_a !== m_sc_a) begin
          failures++;
          $display("FAIL sweep_a nz=%0d: count=%0d dec=%b scale=%0d, expected count=%0d dec=%b scale=%0d",
                   nz, count_a, {sb_a, fs_a, ci_a}, sc_a, m_cnt_a, exp, m_sc_a);
        end
      end
    end
  endtask

  task automatic test_scale;
    logic [3:0] exp;
    for (int i = 0; i < 340; i++) begin
      cyc_a(0, 0, 0, (i < 170) ? 3'd5 : 3'd7);
      exp = ref_dec(m_cnt_a, m_nz_a, 4, 16, 32, 64);
      checks++;
      if (sc_a !== ((i < 170) ? 2'd1 : 2'd2) || {sb_a, fs_a, ci_a} !== exp ||
          count_a !== 8'(m_cnt_a)) begin
        failures++;
        $display("FAIL scale step=%0d: scale=%0d dec=%b count=%0d, expected dec=%b count=%0d",
                 i, sc_a, {sb_a, fs_a, ci_a}, count_a, exp, m_cnt_a);
      end
    end
  endtask

  task automatic test_freeze;
    logic [3:0] exp;
    cyc_a(1, 0, 0, 3'd1);
    while (m_cnt_a != 17) cyc_a(0, 0, 0, 3'd1);
    for (int i = 0; i < 10; i++) begin
      cyc_a(0, 1, (i == 1 || i == 4 || i == 7), 3'd1);
      exp = ref_dec(m_cnt_a, m_nz_a, 4, 16, 32, 64);
      checks++;
      if (count_a !== 8'(m_cnt_a) || {sb_a, fs_a, ci_a} !== exp) begin
        failures++;
        $display("FAIL freeze step=%0d: count=%0d dec=%b, expected count=%0d dec=%b",
                 i, count_a, {sb_a, fs_a, ci_a}, m_cnt_a, exp);
      end
    end
    checks++;
    if (count_a !== 8'd20 || sb_a !== 1'b1) begin
      failures++;
      $display("FAIL freeze_end: count=%0d sb=%b, expected 20 1", count_a, sb_a);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp;
    while (m_cnt_a != 34) cyc_a(0, 0, 0, 3'd2);
    cyc_a(1, 0, 1, 3'd2);
    checks++;
    if (count_a !== 8'd0 || sb_a !== 1'b0 || ci_a !== 2'd0 || fs_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: count=%0d sb=%b fs=%b idx=%0d, expected 0 0 1 0",
               count_a, sb_a, fs_a, ci_a);
    end
    cyc_a(0, 0, 1, 3'd2);
    checks++;
    if (count_a !== 8'd1) begin
      failures++;
      $display("FAIL single_step: count=%0d, expected 1", count_a);
    end
    for (int i = 0; i < 40; i++) begin
      cyc_a(0, 0, 0, 3'd2);
      exp = ref_dec(m_cnt_a, m_nz_a, 4, 16, 32, 64);
      checks++;
      if (count_a !== 8'(m_cnt_a) || {sb_a, fs_a, ci_a} !== exp) begin
        failures++;
        $display("FAIL medium_after_reset: count=%0d dec=%b, expected count=%0d dec=%b",
                 count_a, {sb_a, fs_a, ci_a}, m_cnt_a, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] exp;
    for (int i = 0; i < 600; i++) begin
      cyc_a(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      exp = ref_dec(m_cnt_a, m_nz_a, 4, 16, 32, 64);
      checks++;
      if (count_a !== 8'(m_cnt_a) || {sb_a, fs_a, ci_a} !== exp || sc_a !== m_sc_a) begin
        failures++;
        $display("FAIL random step=%0d: count=%0d dec=%b scale=%0d, expected count=%0d dec=%b scale=%0d",
                 i, count_a, {sb_a, fs_a, ci_a}, sc_a, m_cnt_a, exp, m_sc_a);
      end
    end
  endtask

  task automatic test_sweep_b;
    logic [3:0] exp;
    cyc_b(1, 0, 0, 3'd1);
    for (int nz = 1; nz <= 6; nz++) begin
      for (int i = 0; i < 228; i++) begin
        cyc_b(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 3'(nz));
        exp = ref_dec(m_cnt_b, m_nz_b, 2, 8, 16, 32);
        checks++;
        if (count_b !== 8'(m_cnt_b) || {sb_b, fs_b, ci_b} !== exp || sc_b !== m_sc_b) begin
          failures++;
          $display("FAIL sweep_b nz=%0d: count=%0d dec=%b scale=%0d, expected count=%0d dec=%b scale=%0d",
                   nz, count_b, {sb_b, fs_b, ci_b}, sc_b, m_cnt_b, exp, m_sc_b);
        end
      end
    end
  endtask

  initial begin
    pre_a = 1'b1; pec_a = 1'b1; hm_a = 1'b0; nz_a = 3'd0;
    pre_b = 1'b1; pec_b = 1'b1; hm_b = 1'b0; nz_b = 3'd0;
    m_cnt_a = 0; m_cnt_b = 0;
    m_nz_a = 3'd0; m_nz_b = 3'd0;
    m_sc_a = 2'd0; m_sc_b = 2'd0;
    test_reset;
    test_sweep_a;
    test_scale;
    test_freeze;
    test_reset_mid;
    test_random;
    test_sweep_b;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
